// File: rtl/nor_seq_pkg.sv
// rtl/nor_seq_pkg.sv - shared state encoding and vector helpers for the NOR gate sequencer
package nor_seq_pkg;

  localparam int MAX_W = 32;

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, FINISH} state_t;

  typedef struct packed {
    logic [MAX_W-1:0] a;
    logic [MAX_W-1:0] b;
    logic [MAX_W-1:0] c;
  } vec_t;

  function automatic logic [MAX_W-1:0] nor_exp(input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b);
    return ~(a | b);
  endfunction

  // Phase 0 holds a high, phase 1 holds it low; b carries a single walking zero.
  function automatic vec_t walk_vec(input int unsigned k, input int unsigned width);
    vec_t             v;
    logic [MAX_W-1:0] mask;
    int unsigned      i;
    mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
    i    = (k >= width) ? (k - width) : k;
    v.c  = MAX_W'(1) << i;
    v.a  = (k < width) ? mask : '0;
    v.b  = ~v.c & mask;
    return v;
  endfunction

endpackage

// File: rtl/nor_quad_pattern_seq_timer.sv
// rtl/nor_quad_pattern_seq_timer.sv - per-vector hold timer, counts 0..HOLD-1 and flags the last count
module seq_hold_timer #(
  parameter  int HOLD = 10,
  localparam int TW   = (HOLD > 1) ? $clog2(HOLD) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_en,
  output logic [TW-1:0] o_count,
  output logic          o_last
);

  logic [TW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= '0;
    end else if (i_en && (r_count != TW'(HOLD - 1))) begin
      r_count <= r_count + TW'(1);
    end
  end

  assign o_count = r_count;
  assign o_last  = (r_count == TW'(HOLD - 1));

endmodule

// File: rtl/nor_quad_pattern_seq.sv
// rtl/nor_quad_pattern_seq.sv - truth-table sweep driver and checker for a quad 2-input NOR gate
module nor_quad_pattern_seq
  import nor_seq_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int HOLD  = 10,
  localparam int EW    = $clog2(2 * WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] y_in,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [EW-1:0]    err_cnt,
  output logic             fail
);

  localparam int NV = 2 * WIDTH;
  localparam int KW = $clog2(NV);
  localparam int TW = $clog2(HOLD);

  state_t           r_state;
  state_t           w_next;
  logic [KW-1:0]    r_k;
  logic [KW-1:0]    w_k_load;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] w_exp;
  logic [EW-1:0]    r_err;
  logic [TW-1:0]    w_t;
  logic             w_t_last;
  logic             w_load;
  logic             w_check;
  logic             w_last_k;
  logic             w_mismatch;
  vec_t             w_vec;
  logic             w_unused;

  seq_hold_timer #(.HOLD(HOLD)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_en    (r_state == APPLY),
    .o_count (w_t),
    .o_last  (w_t_last)
  );

  // Next vector is vector 0 when launching from IDLE, otherwise k+1.
  assign w_last_k   = (r_k == KW'(NV - 1));
  assign w_k_load   = (r_state == IDLE) ? '0 : (r_k + KW'(1));
  assign w_vec      = walk_vec(32'(w_k_load), WIDTH);
  assign w_unused   = ^w_vec;
  assign w_exp      = WIDTH'(nor_exp(MAX_W'(r_a), MAX_W'(r_b)));
  assign w_mismatch = (y_in != w_exp);
  assign w_check    = (r_state == CHECK) && w_t_last;
  assign w_load     = ((r_state == IDLE) && start) || (r_state == CHECK);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = APPLY;
      APPLY:   if (w_t == TW'(HOLD - 2)) w_next = CHECK;
      CHECK:   w_next = w_last_k ? FINISH : APPLY;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_err   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_k   <= w_k_load;
            r_a   <= w_vec.a[WIDTH-1:0];
            r_b   <= w_vec.b[WIDTH-1:0];
            r_err <= '0;
          end
        end
        CHECK: begin
          if (w_check && w_mismatch && (r_err != '1)) r_err <= r_err + EW'(1);
          // a and b always change on the same edge so the gate never sees a mixed vector.
          if (w_last_k) begin
            r_a <= '0;
            r_b <= '0;
          end else begin
            r_k <= w_k_load;
            r_a <= w_vec.a[WIDTH-1:0];
            r_b <= w_vec.b[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign a       = r_a;
  assign b       = r_b;
  assign busy    = (r_state == APPLY) || (r_state == CHECK);
  assign done    = (r_state == FINISH);
  assign err_cnt = r_err;
  assign fail    = (r_err != '0);

endmodule

// File: tb/tb_nor_quad_pattern_seq.sv
// tb/tb_nor_quad_pattern_seq.sv - self-checking bench for nor_quad_pattern_seq
module tb_nor_quad_pattern_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       start2;
  logic [3:0] y4, a4, b4, err4;
  logic       busy4, done4, fail4;
  logic [1:0] y2, a2, b2;
  logic [2:0] err2;
  logic       busy2, done2, fail2;
  logic [3:0] am, om, cur_x;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Gate model with injectable faults: and-mask, or-mask, per-vector xor.
  assign y4 = (((~(a4 | b4)) & am) | om) ^ cur_x;
  assign y2 = 2'b11;

  nor_quad_pattern_seq #(.WIDTH(4), .HOLD(10)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .y_in(y4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .err_cnt(err4), .fail(fail4)
  );

  nor_quad_pattern_seq #(.WIDTH(2), .HOLD(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .y_in(y2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .err_cnt(err2), .fail(fail2)
  );

  typedef struct {
    string      nm;
    logic [3:0] and_m;
    logic [3:0] or_m;
    int         err;
  } vec_row_t;

  vec_row_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_a(input int k);
    return (k < 4) ? 4'hF : 4'h0;
  endfunction

  function automatic logic [3:0] exp_b(input int k);
    return ~(4'b0001 << (k % 4));
  endfunction

  function automatic int model_err(input logic [3:0] and_m, input logic [3:0] or_m,
                                   input logic [3:0] xm[8]);
    int         n;
    logic [3:0] e;
    logic [3:0] yy;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      e  = ~(exp_a(k) | exp_b(k));
      yy = ((e & and_m) | or_m) ^ xm[k];
      if (yy != e) n++;
    end
    return n;
  endfunction

  task automatic run4(input string nm, input logic [3:0] and_m, input logic [3:0] or_m,
                      input bit randx, input int rst_at, input int extra_at,
                      input bit hold, input int want_err);
    logic [3:0] xm[8];
    int         want;
    for (int k = 0; k < 8; k++)
      xm[k] = (randx && ($urandom_range(0, 2) == 0)) ? 4'($urandom_range(1, 15)) : 4'h0;
    want  = (want_err >= 0) ? want_err : model_err(and_m, or_m, xm);
    am    = and_m;
    om    = or_m;
    cur_x = 4'h0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      cur_x = xm[c / 10];
      start = hold || (c == extra_at);
      if (c == rst_at) begin
        rst = 1'b1;
        #1;
        chk({nm, "_rst"}, {busy4, done4, a4, b4, err4, fail4}, 32'h0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        cur_x = 4'h0;
        return;
      end
      chk({nm, "_cyc"}, {busy4, done4, a4, b4}, {1'b1, 1'b0, exp_a(c / 10), exp_b(c / 10)});
    end
    @(negedge clk);
    cur_x = 4'h0;
    chk({nm, "_done"}, {busy4, done4, a4, b4, err4, fail4},
        {1'b0, 1'b1, 4'h0, 4'h0, 4'(want), (want != 0)});
    if (!hold) begin
      start = 1'b0;
      @(negedge clk);
      chk({nm, "_post"}, {busy4, done4, err4}, {1'b0, 1'b0, 4'(want)});
    end
  endtask

  initial begin
    int  n;
    bit  seen;
    rst    = 1'b1;
    start  = 1'b0;
    start2 = 1'b0;
    am     = 4'hF;
    om     = 4'h0;
    cur_x  = 4'h0;
    repeat (3) @(negedge clk);
    chk("reset4", {busy4, done4, a4, b4, err4, fail4}, 32'h0);
    chk("reset2", {busy2, done2, a2, b2, err2, fail2}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle4", {busy4, done4, a4, b4, err4, fail4}, 32'h0);

    tbl[0] = '{"golden",   4'hF, 4'h0, 0};
    tbl[1] = '{"stuck1_y2", 4'hF, 4'h4, 7};
    tbl[2] = '{"stuck0_y0", 4'hE, 4'h0, 1};
    tbl[3] = '{"y_zero",   4'h0, 4'h0, 4};
    tbl[4] = '{"stuck1_y3", 4'hF, 4'h8, 7};
    for (int i = 0; i < 5; i++)
      run4(tbl[i].nm, tbl[i].and_m, tbl[i].or_m, 1'b0, -1, -1, 1'b0, tbl[i].err);

    run4("start_busy", 4'hF, 4'h0, 1'b0, -1, 20, 1'b0, 0);

    run4("rst_mid", 4'hF, 4'h4, 1'b0, 35, -1, 1'b0, 7);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done4) seen = 1'b1;
    end
    chk("rst_no_done", {31'h0, seen}, 32'h0);
    run4("after_rst", 4'hF, 4'h0, 1'b0, -1, -1, 1'b0, 0);

    run4("b2b", 4'hF, 4'h4, 1'b0, -1, -1, 1'b1, 7);
    am = 4'hF;
    om = 4'h0;
    @(negedge clk);
    chk("b2b_idle", {busy4, done4, err4}, {1'b0, 1'b0, 4'd7});
    @(negedge clk);
    start = 1'b0;
    chk("b2b_restart", {busy4, a4, b4, err4, fail4}, {1'b1, 4'hF, 4'hE, 4'd0, 1'b0});
    n = 0;
    while (!done4 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_second_done", {done4, err4}, {1'b1, 4'd0});
    @(negedge clk);

    for (int r = 0; r < 6; r++)
      run4($sformatf("rand%0d", r), 4'hF, 4'h0, 1'b1, -1, -1, 1'b0, -1);

    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk("w2_cyc", {busy2, done2, a2, b2},
          {1'b1, 1'b0, ((c / 2) < 2) ? 2'b11 : 2'b00, ~(2'b01 << ((c / 2) % 2))});
      @(negedge clk);
    end
    chk("w2_done", {busy2, done2, a2, b2, err2, fail2}, {1'b0, 1'b1, 2'b00, 2'b00, 3'd4, 1'b1});
    @(negedge clk);
    chk("w2_post", {busy2, done2, err2}, {1'b0, 1'b0, 3'd4});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
